// File: rtl/axi_slave_sram_pkg.sv
// Shared types and constants for the AXI4 SRAM responder slice.
package axi_slave_sram_pkg;

  localparam int ID_W    = 4;
  localparam int ADDR_W  = 32;
  localparam int LEN_W   = 8;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int DATA_W  = 32;
  localparam int STRB_W  = 4;
  localparam int RESP_W  = 2;

  localparam logic [BURST_W-1:0] BURST_FIXED = 2'b00;
  localparam logic [BURST_W-1:0] BURST_INCR  = 2'b01;
  localparam logic [BURST_W-1:0] BURST_WRAP  = 2'b10;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
  localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WDATA = 3'd1,
    ST_BRESP = 3'd2,
    ST_RMEM  = 3'd3,
    ST_RDATA = 3'd4
  } state_e;

  // Slave errors outrank decode errors.
  function automatic logic [RESP_W-1:0] resp_sel(input logic slv_err, input logic dec_err);
    if (slv_err) begin
      return RESP_SLVERR;
    end else if (dec_err) begin
      return RESP_DECERR;
    end else begin
      return RESP_OKAY;
    end
  endfunction

endpackage

// File: rtl/axi_slave_sram_if.sv
// AXI4 bus bundle between axi_master and axi_slave_sram.
interface axi_slave_sram_if
  import axi_slave_sram_pkg::*;
();

  logic [ID_W-1:0]    awid;
  logic [ADDR_W-1:0]  awaddr;
  logic [LEN_W-1:0]   awlen;
  logic [SIZE_W-1:0]  awsize;
  logic [BURST_W-1:0] awburst;
  logic               awvalid;
  logic               awready;
  logic [DATA_W-1:0]  wdata;
  logic [STRB_W-1:0]  wstrb;
  logic               wlast;
  logic               wvalid;
  logic               wready;
  logic [ID_W-1:0]    bid;
  logic [RESP_W-1:0]  bresp;
  logic               bvalid;
  logic               bready;
  logic [ID_W-1:0]    arid;
  logic [ADDR_W-1:0]  araddr;
  logic [LEN_W-1:0]   arlen;
  logic [SIZE_W-1:0]  arsize;
  logic [BURST_W-1:0] arburst;
  logic               arvalid;
  logic               arready;
  logic [ID_W-1:0]    rid;
  logic [DATA_W-1:0]  rdata;
  logic [RESP_W-1:0]  rresp;
  logic               rlast;
  logic               rvalid;
  logic               rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awready, wready, bid, bresp, bvalid,
    output arready, rid, rdata, rresp, rlast, rvalid
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/axi_slave_sram_burst_addr_gen.sv
// Combinational AXI4 next-beat address and burst legality; reusable by other responders.
module axi_burst_addr_gen
  import axi_slave_sram_pkg::*;
(
  input  logic [ADDR_W-1:0]  addr,
  input  logic [LEN_W-1:0]   len,
  input  logic [SIZE_W-1:0]  size,
  input  logic [BURST_W-1:0] burst,
  output logic [ADDR_W-1:0]  next_addr,
  output logic               legal
);

  logic [ADDR_W-1:0] step_s;
  logic [ADDR_W-1:0] incr_addr_s;
  logic [ADDR_W-1:0] wrap_mask_s;
  logic              wrap_len_ok_s;

  // Next address: the wrap window is ((len+1)<<size) bytes, aligned to its own size.
  always_comb begin
    step_s      = 32'd1 << size;
    incr_addr_s = addr + step_s;
    wrap_mask_s = ((ADDR_W'(len) + 32'd1) << size) - 32'd1;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = incr_addr_s;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask_s) | (incr_addr_s & wrap_mask_s);
      default:     next_addr = addr;
    endcase
  end

  // Legality: reserved burst, oversize beats and non power-of-two wrap lengths.
  always_comb begin
    case (len)
      8'd1, 8'd3, 8'd7, 8'd15: wrap_len_ok_s = 1'b1;
      default:                 wrap_len_ok_s = 1'b0;
    endcase
    if (burst == 2'b11) begin
      legal = 1'b0;
    end else if (size > 3'd2) begin
      legal = 1'b0;
    end else if ((burst == BURST_WRAP) && !wrap_len_ok_s) begin
      legal = 1'b0;
    end else begin
      legal = 1'b1;
    end
  end

endmodule

// File: rtl/axi_slave_sram.sv
// AXI4 responder in front of a single-port word SRAM, one burst at a time.
// Optional AXI_SLAVE_DECERR_EN: out-of-window bursts answer DECERR instead of aliasing.
module axi_slave_sram
  import axi_slave_sram_pkg::*;
#(
  parameter int          MEM_ADDR_W = 14,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  aclk,
  input  logic                  areset_n,
  axi_slave_sram_if.slave       axi,
  output logic                  mem_cs,
  output logic [STRB_W-1:0]     mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

`ifdef AXI_SLAVE_DECERR_EN
  localparam bit DECERR_EN = 1'b1;
`else
  localparam bit DECERR_EN = 1'b0;
`endif

  state_e             state_r;
  logic               rdy_r;
  logic [ID_W-1:0]    id_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [LEN_W-1:0]   len_r;
  logic [SIZE_W-1:0]  size_r;
  logic [BURST_W-1:0] burst_r;
  logic [LEN_W-1:0]   beat_r;
  logic               err_r;
  logic               ill_r;
  logic               dec_r;

  logic [ADDR_W-1:0]  gen_addr_s;
  logic [LEN_W-1:0]   gen_len_s;
  logic [SIZE_W-1:0]  gen_size_s;
  logic [BURST_W-1:0] gen_burst_s;
  logic [ADDR_W-1:0]  next_addr_s;
  logic               legal_s;
  logic               window_hit_s;
  logic               dec_s;
  logic               idle_s;
  logic               access_ok_s;

  assign idle_s = (state_r == ST_IDLE) && rdy_r;

  // While idle the generator judges the incoming request; otherwise it steps the latched burst.
  always_comb begin
    if (state_r == ST_IDLE) begin
      if (axi.awvalid) begin
        gen_addr_s  = axi.awaddr;
        gen_len_s   = axi.awlen;
        gen_size_s  = axi.awsize;
        gen_burst_s = axi.awburst;
      end else begin
        gen_addr_s  = axi.araddr;
        gen_len_s   = axi.arlen;
        gen_size_s  = axi.arsize;
        gen_burst_s = axi.arburst;
      end
    end else begin
      gen_addr_s  = addr_r;
      gen_len_s   = len_r;
      gen_size_s  = size_r;
      gen_burst_s = burst_r;
    end
  end

  axi_burst_addr_gen u_addr_gen (
    .addr      (gen_addr_s),
    .len       (gen_len_s),
    .size      (gen_size_s),
    .burst     (gen_burst_s),
    .next_addr (next_addr_s),
    .legal     (legal_s)
  );

  assign window_hit_s = (gen_addr_s[ADDR_W-1:MEM_ADDR_W+2] == BASE_ADDR[ADDR_W-1:MEM_ADDR_W+2]);
  assign dec_s        = DECERR_EN && !window_hit_s;
  assign access_ok_s  = !ill_r && !dec_r;

  assign axi.awready = idle_s;
  assign axi.arready = idle_s && !axi.awvalid;
  assign axi.wready  = (state_r == ST_WDATA);
  assign axi.bvalid  = (state_r == ST_BRESP);
  assign axi.bid     = axi.bvalid ? id_r : {ID_W{1'b0}};
  assign axi.bresp   = axi.bvalid ? resp_sel(ill_r || err_r, dec_r) : RESP_OKAY;
  assign axi.rvalid  = (state_r == ST_RDATA);
  assign axi.rid     = axi.rvalid ? id_r : {ID_W{1'b0}};
  assign axi.rdata   = axi.rvalid ? mem_rdata : {DATA_W{1'b0}};
  assign axi.rresp   = axi.rvalid ? resp_sel(ill_r, dec_r) : RESP_OKAY;
  assign axi.rlast   = axi.rvalid && (beat_r == len_r);

  // SRAM strobes: writes pass straight through on the W beat, reads issue from RMEM.
  always_comb begin
    mem_cs    = 1'b0;
    mem_we    = {STRB_W{1'b0}};
    mem_addr  = addr_r[MEM_ADDR_W+1:2];
    mem_wdata = {DATA_W{1'b0}};
    case (state_r)
      ST_WDATA: begin
        if (axi.wvalid && access_ok_s) begin
          mem_cs    = 1'b1;
          mem_we    = axi.wstrb;
          mem_wdata = axi.wdata;
        end else begin
          mem_cs = 1'b0;
        end
      end
      ST_RMEM: begin
        if (access_ok_s) begin
          mem_cs = 1'b1;
        end else begin
          mem_cs = 1'b0;
        end
      end
      default: mem_cs = 1'b0;
    endcase
  end

  // Burst FSM; rdy_r keeps both address readies low through reset and the cycle after it.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_r <= ST_IDLE;
      rdy_r   <= 1'b0;
      id_r    <= {ID_W{1'b0}};
      addr_r  <= {ADDR_W{1'b0}};
      len_r   <= {LEN_W{1'b0}};
      size_r  <= {SIZE_W{1'b0}};
      burst_r <= {BURST_W{1'b0}};
      beat_r  <= {LEN_W{1'b0}};
      err_r   <= 1'b0;
      ill_r   <= 1'b0;
      dec_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!rdy_r) begin
            rdy_r <= 1'b1;
          end else if (axi.awvalid || axi.arvalid) begin
            id_r    <= axi.awvalid ? axi.awid : axi.arid;
            addr_r  <= gen_addr_s;
            len_r   <= gen_len_s;
            size_r  <= gen_size_s;
            burst_r <= gen_burst_s;
            beat_r  <= {LEN_W{1'b0}};
            err_r   <= 1'b0;
            ill_r   <= !legal_s;
            dec_r   <= dec_s;
            rdy_r   <= 1'b0;
            state_r <= axi.awvalid ? ST_WDATA : ST_RMEM;
          end else begin
            rdy_r <= 1'b1;
          end
        end
        ST_WDATA: begin
          if (axi.wvalid) begin
            beat_r <= beat_r + 8'd1;
            addr_r <= next_addr_s;
            if (axi.wlast) begin
              err_r   <= err_r || (beat_r != len_r);
              state_r <= ST_BRESP;
            end else if (beat_r == len_r) begin
              err_r <= 1'b1;
            end else begin
              err_r <= err_r;
            end
          end else begin
            beat_r <= beat_r;
          end
        end
        ST_BRESP: begin
          if (axi.bready) begin
            rdy_r   <= 1'b1;
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_BRESP;
          end
        end
        ST_RMEM: state_r <= ST_RDATA;
        ST_RDATA: begin
          if (axi.rready) begin
            if (beat_r == len_r) begin
              rdy_r   <= 1'b1;
              state_r <= ST_IDLE;
            end else begin
              beat_r  <= beat_r + 8'd1;
              addr_r  <= next_addr_s;
              state_r <= ST_RMEM;
            end
          end else begin
            state_r <= ST_RDATA;
          end
        end
        default: begin
          rdy_r   <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
